// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch -> decode -> issue handshake bundle.
// master is the fetch/issue side, slave is the decode stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     in_instr_i;
  logic [XLEN-1:0] in_pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [31:0]     out_instr_o;
  logic [4:0]      out_rd_o;
  logic [4:0]      out_rs1_o;
  logic [4:0]      out_rs2_o;
  logic            out_rd_v_o;
  logic            out_rs1_v_o;
  logic            out_rs2_v_o;
  logic [XLEN-1:0] out_imm_o;
  logic [2:0]      out_unit_o;
  logic [3:0]      out_op_o;
  logic            out_word_o;
  logic            out_illegal_o;

  modport master (
    output flush_i, in_valid_i, in_instr_i,
    output in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o,
    input  out_instr_o, out_rd_o, out_rs1_o,
    input  out_rs2_o, out_rd_v_o, out_rs1_v_o,
    input  out_rs2_v_o, out_imm_o, out_unit_o,
    input  out_op_o, out_word_o, out_illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_instr_i,
    input  in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o,
    output out_instr_o, out_rd_o, out_rs1_o,
    output out_rs2_o, out_rd_v_o, out_rs1_v_o,
    output out_rs2_v_o, out_imm_o, out_unit_o,
    output out_op_o, out_word_o, out_illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 decode with 2-entry skid.
// Ports: clk, reset (async, high), bus (decode_stage_if.slave).
module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit M_EXT   = 1'b1,
  parameter bit CSR_EXT = 1'b1
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] U_ALU = 3'd0;
  localparam logic [2:0] U_BR  = 3'd1;
  localparam logic [2:0] U_LSU = 3'd2;
  localparam logic [2:0] U_MUL = 3'd3;
  localparam logic [2:0] U_DIV = 3'd4;
  localparam logic [2:0] U_CSR = 3'd5;
  localparam logic [2:0] U_SYS = 3'd6;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_v;
    logic            rs1_v;
    logic            rs2_v;
    logic [XLEN-1:0] imm;
    logic [2:0]      unit;
    logic [3:0]      op;
    logic            word;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  logic [31:0] i;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign i   = bus.in_instr_i;
  assign opc = i[6:0];
  assign f3  = i[14:12];
  assign f7  = i[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] imm_u, imm_j, imm_z;

  assign imm_i = XLEN'($signed(i[31:20]));
  assign imm_s = XLEN'($signed({i[31:25], i[11:7]}));
  assign imm_b = XLEN'($signed({i[31], i[7],
                   i[30:25], i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i[31], i[19:12],
                   i[20], i[30:21], 1'b0}));
  assign imm_z = XLEN'(i[19:15]);

  logic            ill, rdv, rs1v, rs2v, word;
  logic [2:0]      unit;
  logic [3:0]      op;
  logic [XLEN-1:0] imm;
  dec_t            dec;

  always_comb begin
    ill  = 1'b0;
    rdv  = 1'b0;
    rs1v = 1'b0;
    rs2v = 1'b0;
    word = 1'b0;
    unit = U_ALU;
    imm  = '0;
    op   = {i[30], f3};
    unique case (1'b1)
      opc == OP_LUI: begin
        rdv = 1'b1;
        imm = imm_u;
        op  = 4'd0;
      end
      opc == OP_AUIPC: begin
        rdv = 1'b1;
        imm = imm_u;
        op  = 4'd8;
      end
      opc == OP_JAL: begin
        rdv  = 1'b1;
        imm  = imm_j;
        unit = U_BR;
      end
      opc == OP_JALR: begin
        ill  = f3 != 3'b000;
        rdv  = 1'b1;
        rs1v = 1'b1;
        imm  = imm_i;
        unit = U_BR;
      end
      opc == OP_BR: begin
        ill  = f3[2:1] == 2'b01;
        rs1v = 1'b1;
        rs2v = 1'b1;
        imm  = imm_b;
        unit = U_BR;
      end
      opc == OP_LD: begin
        ill  = (f3 == 3'b111) ||
               (f3 inside {3'b011, 3'b110} && !RV64);
        rdv  = 1'b1;
        rs1v = 1'b1;
        imm  = imm_i;
        unit = U_LSU;
      end
      opc == OP_ST: begin
        ill  = f3[2] || (f3 == 3'b011 && !RV64);
        rs1v = 1'b1;
        rs2v = 1'b1;
        imm  = imm_s;
        unit = U_LSU;
      end
      opc == OP_IMM: begin
        rdv  = 1'b1;
        rs1v = 1'b1;
        imm  = imm_i;
        // shamt[5] is only meaningful on RV64
        if (f3 == 3'b001)
          ill = (f7[6:1] != 6'b0) || (f7[0] && !RV64);
        else if (f3 == 3'b101)
          ill = (f7[6:1] != 6'b0 &&
                 f7[6:1] != 6'b010000) ||
                (f7[0] && !RV64);
      end
      opc == OP_REG: begin
        rdv  = 1'b1;
        rs1v = 1'b1;
        rs2v = 1'b1;
        if (f7 == 7'b0000001) begin
          ill  = !M_EXT;
          unit = f3[2] ? U_DIV : U_MUL;
        end else if (f7 == 7'b0100000) begin
          ill = !(f3 inside {3'b000, 3'b101});
        end else begin
          ill = f7 != 7'b0;
        end
      end
      opc == OP_IMM32: begin
        rdv  = 1'b1;
        rs1v = 1'b1;
        word = 1'b1;
        imm  = imm_i;
        if (f3 == 3'b001)
          ill = f7 != 7'b0;
        else if (f3 == 3'b101)
          ill = f7 != 7'b0 && f7 != 7'b0100000;
        else
          ill = f3 != 3'b000;
        ill = ill || !RV64;
      end
      opc == OP_REG32: begin
        rdv  = 1'b1;
        rs1v = 1'b1;
        rs2v = 1'b1;
        word = 1'b1;
        if (f7 == 7'b0000001) begin
          ill  = !M_EXT ||
                 f3 inside {3'b001, 3'b010, 3'b011};
          unit = (f3 == 3'b000) ? U_MUL : U_DIV;
        end else if (f7 == 7'b0) begin
          ill = !(f3 inside {3'b000, 3'b001, 3'b101});
        end else if (f7 == 7'b0100000) begin
          ill = !(f3 inside {3'b000, 3'b101});
        end else begin
          ill = 1'b1;
        end
        ill = ill || !RV64;
      end
      opc == OP_FENCE: begin
        ill  = f3 != 3'b000;
        unit = U_SYS;
      end
      opc == OP_SYS: begin
        if (f3 == 3'b000) begin
          unit = U_SYS;
          ill  = !(i inside {32'h00000073, 32'h00100073,
                             32'h30200073, 32'h10200073});
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          ill  = !CSR_EXT;
          unit = U_CSR;
          rdv  = 1'b1;
          rs1v = !f3[2];
          imm  = f3[2] ? imm_z : imm_i;
        end
      end
      default: ill = 1'b1;
    endcase

    dec.pc      = bus.in_pc_i;
    dec.instr   = i;
    dec.rd      = i[11:7];
    dec.rs1     = i[19:15];
    dec.rs2     = i[24:20];
    dec.rd_v    = !ill && rdv && (i[11:7] != 5'd0);
    dec.rs1_v   = !ill && rs1v;
    dec.rs2_v   = !ill && rs2v;
    dec.imm     = ill ? '0 : imm;
    dec.unit    = ill ? U_SYS : unit;
    dec.op      = op;
    dec.word    = !ill && word;
    dec.illegal = ill;
  end

  state_t state;
  dec_t   main_q, skid_q;
  logic   vld_q, rdy_q;
  logic   acc, pop;

  assign acc = bus.in_valid_i && rdy_q;
  assign pop = vld_q && bus.out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush_i) begin
      state <= EMPTY;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= dec;
            vld_q  <= 1'b1;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_q <= dec;
          end else if (pop) begin
            vld_q <= 1'b0;
            state <= EMPTY;
          end else if (acc) begin
            skid_q <= dec;
            rdy_q  <= 1'b0;
            state  <= TWO;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            rdy_q  <= 1'b1;
            state  <= ONE;
          end
        end
        default: begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready_o    = rdy_q;
  assign bus.out_valid_o   = vld_q;
  assign bus.out_pc_o      = main_q.pc;
  assign bus.out_instr_o   = main_q.instr;
  assign bus.out_rd_o      = main_q.rd;
  assign bus.out_rs1_o     = main_q.rs1;
  assign bus.out_rs2_o     = main_q.rs2;
  assign bus.out_rd_v_o    = main_q.rd_v;
  assign bus.out_rs1_v_o   = main_q.rs1_v;
  assign bus.out_rs2_v_o   = main_q.rs2_v;
  assign bus.out_imm_o     = main_q.imm;
  assign bus.out_unit_o    = main_q.unit;
  assign bus.out_op_o      = main_q.op;
  assign bus.out_word_o    = main_q.word;
  assign bus.out_illegal_o = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two decode_stage builds (RV32+M+CSR, RV64 bare)
// driven in lockstep and checked against a mask/match reference.
module tb_decode_stage;

  localparam int FU = 0, FJ = 1, FI = 2, FB = 3;
  localparam int FS = 4, FR = 5, FSH = 6, FSYS = 7;
  localparam int FCR = 8, FCI = 9;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rdv;
    logic        rs1v;
    logic        rs2v;
    logic [63:0] imm;
    logic [2:0]  unit;
    logic [3:0]  op;
    logic        word;
    logic        ill;
  } ent_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          fmt;
    logic [2:0]  unit;
    bit          r64;
    bit          m;
    bit          csr;
    bit          word;
  } row_t;

  row_t rows[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;
  bit          run = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  ent_t        q32[$];
  ent_t        q64[$];
  logic [31:0] emitted[$];

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) b32 ();
  decode_stage_if #(.XLEN(64)) b64 ();

  assign b32.flush_i     = flush;
  assign b32.in_valid_i  = in_valid;
  assign b32.in_instr_i  = in_instr;
  assign b32.in_pc_i     = in_pc[31:0];
  assign b32.out_ready_i = out_ready;
  assign b64.flush_i     = flush;
  assign b64.in_valid_i  = in_valid;
  assign b64.in_instr_i  = in_instr;
  assign b64.in_pc_i     = in_pc;
  assign b64.out_ready_i = out_ready;

  decode_stage #(
    .XLEN(32), .M_EXT(1'b1), .CSR_EXT(1'b1)
  ) u32 (
    .clk(clk), .reset(reset), .bus(b32)
  );

  decode_stage #(
    .XLEN(64), .M_EXT(1'b0), .CSR_EXT(1'b0)
  ) u64 (
    .clk(clk), .reset(reset), .bus(b64)
  );

  ent_t o32, o64;

  always_comb begin
    o32.pc    = 64'(b32.out_pc_o);
    o32.instr = b32.out_instr_o;
    o32.rd    = b32.out_rd_o;
    o32.rs1   = b32.out_rs1_o;
    o32.rs2   = b32.out_rs2_o;
    o32.rdv   = b32.out_rd_v_o;
    o32.rs1v  = b32.out_rs1_v_o;
    o32.rs2v  = b32.out_rs2_v_o;
    o32.imm   = 64'(b32.out_imm_o);
    o32.unit  = b32.out_unit_o;
    o32.op    = b32.out_op_o;
    o32.word  = b32.out_word_o;
    o32.ill   = b32.out_illegal_o;
    o64.pc    = b64.out_pc_o;
    o64.instr = b64.out_instr_o;
    o64.rd    = b64.out_rd_o;
    o64.rs1   = b64.out_rs1_o;
    o64.rs2   = b64.out_rs2_o;
    o64.rdv   = b64.out_rd_v_o;
    o64.rs1v  = b64.out_rs1_v_o;
    o64.rs2v  = b64.out_rs2_v_o;
    o64.imm   = b64.out_imm_o;
    o64.unit  = b64.out_unit_o;
    o64.op    = b64.out_op_o;
    o64.word  = b64.out_word_o;
    o64.ill   = b64.out_illegal_o;
  end

  task automatic chk(string name, logic [191:0] act,
                     logic [191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, act, exp);
  endtask

  task automatic add(logic [31:0] mask, logic [31:0] match,
                     int fmt, logic [2:0] unit, bit r64 = 0,
                     bit m = 0, bit csr = 0, bit word = 0);
    row_t r;
    r.mask = mask; r.match = match; r.fmt = fmt;
    r.unit = unit; r.r64 = r64; r.m = m;
    r.csr = csr; r.word = word;
    rows.push_back(r);
  endtask

  task automatic build_table();
    add(32'h7F, 32'h37, FU, 0);
    add(32'h7F, 32'h17, FU, 0);
    add(32'h7F, 32'h6F, FJ, 1);
    add(32'h707F, 32'h67, FI, 1);
    for (int f = 0; f < 8; f++) begin
      if (f != 2 && f != 3)
        add(32'h707F, 32'h63 | (f << 12), FB, 1);
      if (f != 7)
        add(32'h707F, 32'h03 | (f << 12), FI, 2,
            f == 3 || f == 6);
      if (f < 4)
        add(32'h707F, 32'h23 | (f << 12), FS, 2, f == 3);
      if (f != 1 && f != 5)
        add(32'h707F, 32'h13 | (f << 12), FI, 0);
      add(32'hFE00707F, 32'h33 | (f << 12), FR, 0);
      if (f >= 1 && f <= 3)
        add(32'h707F, 32'h73 | (f << 12), FCR, 5, 0, 0, 1);
      if (f >= 5)
        add(32'h707F, 32'h73 | (f << 12), FCI, 5, 0, 0, 1);
    end
    add(32'hFC00707F, 32'h1013, FSH, 0);
    add(32'hFC00707F, 32'h5013, FSH, 0);
    add(32'hFC00707F, 32'h40005013, FSH, 0);
    add(32'hFE00707F, 32'h40000033, FR, 0);
    add(32'hFE00707F, 32'h40005033, FR, 0);
    add(32'hFE00407F, 32'h02000033, FR, 3, 0, 1);
    add(32'hFE00407F, 32'h02004033, FR, 4, 0, 1);
    add(32'h707F, 32'h1B, FI, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h101B, FI, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h501B, FI, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h4000501B, FI, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h3B, FR, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h103B, FR, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h503B, FR, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h4000003B, FR, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h4000503B, FR, 0, 1, 0, 0, 1);
    add(32'hFE00707F, 32'h0200003B, FR, 3, 1, 1, 0, 1);
    for (int f = 4; f < 8; f++)
      add(32'hFE00707F, 32'h0200003B | (f << 12),
          FR, 4, 1, 1, 0, 1);
    add(32'h707F, 32'h0F, FSYS, 6);
    add(32'hFFFFFFFF, 32'h00000073, FSYS, 6);
    add(32'hFFFFFFFF, 32'h00100073, FSYS, 6);
    add(32'hFFFFFFFF, 32'h30200073, FSYS, 6);
    add(32'hFFFFFFFF, 32'h10200073, FSYS, 6);
  endtask

  function automatic ent_t model(logic [31:0] i,
      logic [63:0] pc, int xlen, bit m, bit csr);
    ent_t e;
    int hit;
    logic [31:0] msk;
    row_t r;
    e = '0;
    e.pc = (xlen == 32) ? {32'b0, pc[31:0]} : pc;
    e.instr = i;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.op = {i[30], i[14:12]};
    hit = -1;
    foreach (rows[k]) begin
      msk = rows[k].mask;
      if (rows[k].fmt == FSH && xlen == 32)
        msk = msk | 32'h0200_0000;
      if (hit < 0 && (i & msk) == rows[k].match &&
          (!rows[k].r64 || xlen == 64) &&
          (!rows[k].m || m) && (!rows[k].csr || csr))
        hit = k;
    end
    if (hit < 0) begin
      e.ill = 1'b1;
      e.unit = 3'd6;
      return e;
    end
    r = rows[hit];
    e.unit = r.unit;
    e.word = r.word;
    case (r.fmt)
      FU: begin
        e.imm = {{32{i[31]}}, i[31:12], 12'b0};
        e.op = i[5] ? 4'd0 : 4'd8;
        e.rdv = 1;
      end
      FJ: begin
        e.imm = {{43{i[31]}}, i[31], i[19:12], i[20],
                 i[30:21], 1'b0};
        e.rdv = 1;
      end
      FI, FSH: begin
        e.imm = {{52{i[31]}}, i[31:20]};
        e.rdv = 1; e.rs1v = 1;
      end
      FB: begin
        e.imm = {{51{i[31]}}, i[31], i[7], i[30:25],
                 i[11:8], 1'b0};
        e.rs1v = 1; e.rs2v = 1;
      end
      FS: begin
        e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
        e.rs1v = 1; e.rs2v = 1;
      end
      FR: begin
        e.rdv = 1; e.rs1v = 1; e.rs2v = 1;
      end
      FCR: begin
        e.imm = {{52{i[31]}}, i[31:20]};
        e.rdv = 1; e.rs1v = 1;
      end
      FCI: begin
        e.imm = {59'b0, i[19:15]};
        e.rdv = 1;
      end
      default: ;
    endcase
    e.rdv = e.rdv && (i[11:7] != 5'd0);
    if (xlen == 32) e.imm[63:32] = '0;
    return e;
  endfunction

  function automatic logic [31:0] gen();
    row_t r;
    if ($urandom_range(0, 7) == 0) return $urandom;
    r = rows[$urandom_range(0, rows.size() - 1)];
    return ($urandom & ~r.mask) | r.match;
  endfunction

  // reference occupancy: ready while fewer than two held
  always @(posedge clk or posedge reset) begin
    bit acc, pop;
    if (reset) begin
      q32.delete();
      q64.delete();
    end else if (flush) begin
      q32.delete();
      q64.delete();
    end else begin
      acc = in_valid && (q32.size() < 2);
      pop = (q32.size() > 0) && out_ready;
      if (pop) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(model(in_instr, in_pc, 32, 1, 1));
        q64.push_back(model(in_instr, in_pc, 64, 0, 0));
      end
    end
  end

  always @(posedge clk)
    if (!reset && b32.out_valid_o && out_ready)
      emitted.push_back(b32.out_instr_o);

  always @(negedge clk) begin
    if (!reset && run) begin
      chk("ready32", b32.in_ready_o, q32.size() < 2);
      chk("valid32", b32.out_valid_o, q32.size() > 0);
      if (q32.size() > 0) chk("entry32", o32, q32[0]);
      chk("ready64", b64.in_ready_o, q64.size() < 2);
      chk("valid64", b64.out_valid_o, q64.size() > 0);
      if (q64.size() > 0) chk("entry64", o64, q64[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " valid32"}, b32.out_valid_o, 0);
    chk({tag, " ready32"}, b32.in_ready_o, 1);
    chk({tag, " data32"}, o32, 0);
    chk({tag, " valid64"}, b64.out_valid_o, 0);
    chk({tag, " ready64"}, b64.in_ready_o, 1);
    chk({tag, " data64"}, o64, 0);
  endtask

  task automatic send1(logic [31:0] ins);
    in_instr = ins;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  ent_t e;
  logic [31:0] lst[4];
  int idx;
  bit acc_now;

  initial begin
    build_table();

    e = model(32'hFFF00093, 0, 32, 1, 1);
    chk("pin addi", {e.unit, e.rd, e.rdv, e.rs1v, e.rs2v,
                     e.imm, e.ill},
        {3'd0, 5'd1, 3'b110, 64'hFFFF_FFFF, 1'b0});
    e = model(32'h022081B3, 0, 32, 1, 1);
    chk("pin mul M", {e.unit, e.op, e.rs2v},
        {3'd3, 4'd0, 1'b1});
    e = model(32'h022081B3, 0, 64, 0, 0);
    chk("pin mul noM", {e.ill, e.unit, e.rdv},
        {1'b1, 3'd6, 1'b0});
    e = model(32'h0010809B, 0, 64, 0, 0);
    chk("pin addiw 64", {e.word, e.imm, e.unit},
        {1'b1, 64'd1, 3'd0});
    e = model(32'h0010809B, 0, 32, 1, 1);
    chk("pin addiw 32", e.ill, 1'b1);

    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    step();
    reset = 1'b0;
    run = 1'b1;

    send1(32'hFFF00093);
    chk("addi valid", b32.out_valid_o, 1);
    chk("addi imm", b32.out_imm_o, 32'hFFFF_FFFF);
    chk("addi rdv", {b32.out_rd_v_o, b32.out_rd_o},
        {1'b1, 5'd1});
    step();
    send1(32'h022081B3);
    chk("mul unit32", b32.out_unit_o, 3'd3);
    chk("mul ill64", {b64.out_illegal_o, b64.out_unit_o},
        {1'b1, 3'd6});
    step();
    send1(32'h0010809B);
    chk("addiw 64", {b64.out_word_o, b64.out_imm_o},
        {1'b1, 64'd1});
    chk("addiw 32", b32.out_illegal_o, 1);
    step();

    lst[0] = 32'h00100093;
    lst[1] = 32'h00208133;
    lst[2] = 32'h00312023;
    lst[3] = 32'hFE000EE3;
    emitted.delete();
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || b32.out_valid_o);
         c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 4);
      in_instr = (idx < 4) ? lst[idx] : 32'h0;
      if (c == 1) chk("bp ready c1", b32.in_ready_o, 1);
      if (c == 2) chk("bp ready c2", b32.in_ready_o, 0);
      acc_now = in_valid && b32.in_ready_o;
      step();
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    chk("bp count", emitted.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("bp order", (k < emitted.size()) ? emitted[k] : 0,
          lst[k]);

    emitted.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00500293;
    step();
    in_instr = 32'h00600313;
    step();
    in_instr = 32'h00700393;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush valid", b32.out_valid_o, 0);
    chk("flush ready", b32.in_ready_o, 1);
    out_ready = 1'b1;
    repeat (4) step();
    chk("flush none out", emitted.size(), 0);

    out_ready = 1'b0;
    send1(32'h00A00513);
    out_ready = 1'b0;
    chk("pre-reset valid", b32.out_valid_o, 1);
    #2 reset = 1'b1;
    #1 chk_zero("midreset");
    step();
    reset = 1'b0;
    send1(32'h00000013);
    chk("post-reset nop",
        {b32.out_valid_o, b32.out_instr_o, b32.out_unit_o,
         b32.out_illegal_o, b32.out_rs1_v_o, b32.out_rd_v_o},
        {1'b1, 32'h13, 3'd0, 1'b0, 1'b1, 1'b0});
    step();

    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 2;
      in_instr = gen();
      in_pc = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
